// File: rtl/multi_cycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control_pkg
// Brief    : Shared state encoding and default constants for the controller.
// Revision : 1.0
// ============================================================================
package multi_cycle_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    localparam int         c_op_w        = 3;
    localparam logic [7:0] c_imm_mask    = 8'b0001_0000;
    localparam logic [7:0] c_wb_mask     = 8'b0011_1111;
    localparam int         c_op_add      = 0;
    localparam int         c_op_mov      = 4;
    localparam int         c_ld_op       = 5;
    localparam int         c_st_op       = 6;
    localparam int         c_halt_op     = 7;
    localparam int         c_mem_timeout = 15;
    localparam int         c_cnt_w       = 16;

    // Counter must hold the value TIMEOUT itself; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage : multi_cycle_control_pkg
`default_nettype wire

// File: rtl/multi_cycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control_if
// Brief    : Fetch/decode, memory handshake and datapath control bundle.
// Revision : 1.0
// ============================================================================
interface multi_cycle_control_if #(
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
);
    logic              start;
    logic [OP_W-1:0]   opcode;
    logic              memReady;
    logic [OP_W-1:0]   aluOp;
    logic              nextIns;
    logic              immediate;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
    logic              done;
    logic              error;
    logic [2:0]        state;
    logic [CNT_W-1:0]  retired;

    // Controller side
    modport master (
        input  start, opcode, memReady,
        output aluOp, nextIns, immediate, regWrite, memRead, memWrite,
               memToReg, done, error, state, retired
    );

    // Datapath / sequencing side
    modport slave (
        output start, opcode, memReady,
        input  aluOp, nextIns, immediate, regWrite, memRead, memWrite,
               memToReg, done, error, state, retired
    );
endinterface : multi_cycle_control_if
`default_nettype wire

// File: rtl/multi_cycle_control_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control_mem_wait_timer
// Brief    : Counts MEM cycles spent waiting for memReady; flags the limit.
// Revision : 1.0
// ============================================================================
module multi_cycle_control_mem_wait_timer
    import multi_cycle_control_pkg::*;
#(
    parameter int TIMEOUT = c_mem_timeout
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int c_tw = timer_width(TIMEOUT);

    logic [c_tw-1:0] r_wait_cnt;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_wait_cnt <= '0;
        end else if (enable && !expired) begin
            r_wait_cnt <= r_wait_cnt + c_tw'(1);
        end
    end

    assign expired = (r_wait_cnt == c_tw'(TIMEOUT));

endmodule : multi_cycle_control_mem_wait_timer
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control
// Brief    : Multi-cycle instruction sequencer with memory timeout and
//            retired-instruction counter; Moore outputs only.
// Revision : 1.0
// ============================================================================
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int                  OP_W        = c_op_w,
    parameter logic [2**OP_W-1:0]  IMM_MASK    = (2**OP_W)'(c_imm_mask),
    parameter logic [2**OP_W-1:0]  WB_MASK     = (2**OP_W)'(c_wb_mask),
    parameter int                  LD_OP       = c_ld_op,
    parameter int                  ST_OP       = c_st_op,
    parameter int                  HALT_OP     = c_halt_op,
    parameter int                  MEM_TIMEOUT = c_mem_timeout,
    parameter int                  CNT_W       = c_cnt_w
) (
    input  logic                  clock,
    input  logic                  reset,
    multi_cycle_control_if.master bus
);
    localparam logic [OP_W-1:0] c_ld   = OP_W'(LD_OP);
    localparam logic [OP_W-1:0] c_st   = OP_W'(ST_OP);
    localparam logic [OP_W-1:0] c_halt = OP_W'(HALT_OP);

    state_t           r_state;
    state_t           w_next_state;
    logic [OP_W-1:0]  r_op_reg;
    logic [CNT_W-1:0] r_retired;

    logic w_is_ld;
    logic w_is_st;
    logic w_timer_clear;
    logic w_timer_enable;
    logic w_timer_expired;

    logic w_next_ins;
    logic w_immediate;
    logic w_reg_write;
    logic w_mem_read;
    logic w_mem_write;
    logic w_mem_to_reg;
    logic w_done;
    logic w_error;

    assign w_is_ld = (r_op_reg == c_ld);
    assign w_is_st = (r_op_reg == c_st);

    assign w_timer_clear  = (r_state == ST_EXECUTE);
    assign w_timer_enable = (r_state == ST_MEM) && !bus.memReady;

    multi_cycle_control_mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_timer_clear),
        .enable  (w_timer_enable),
        .expired (w_timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op_reg  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_op_reg <= bus.opcode;
            end
            if (r_state == ST_WRITEBACK) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (bus.start) w_next_state = ST_FETCH;
            ST_FETCH:     w_next_state = ST_DECODE;
            ST_DECODE:    w_next_state = (bus.opcode == c_halt) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   w_next_state = (w_is_ld || w_is_st) ? ST_MEM : ST_WRITEBACK;
            // A completed handshake wins over an expiring timer in the same cycle.
            ST_MEM: begin
                if (bus.memReady) begin
                    w_next_state = ST_WRITEBACK;
                end else if (w_timer_expired) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_WRITEBACK: w_next_state = ST_FETCH;
            ST_HALT:      w_next_state = ST_HALT;
            ST_ERROR:     w_next_state = ST_ERROR;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_next_ins   = 1'b0;
        w_immediate  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            ST_FETCH:     w_next_ins  = 1'b1;
            ST_EXECUTE:   w_immediate = IMM_MASK[r_op_reg];
            ST_MEM: begin
                w_mem_read  = w_is_ld;
                w_mem_write = w_is_st;
            end
            // Stores never write the register file, whatever their mask bit says.
            ST_WRITEBACK: begin
                w_reg_write  = WB_MASK[r_op_reg] && !w_is_st;
                w_mem_to_reg = w_is_ld;
            end
            ST_HALT:      w_done  = 1'b1;
            ST_ERROR:     w_error = 1'b1;
            default:      ;
        endcase
    end

    assign bus.aluOp     = r_op_reg;
    assign bus.nextIns   = w_next_ins;
    assign bus.immediate = w_immediate;
    assign bus.regWrite  = w_reg_write;
    assign bus.memRead   = w_mem_read;
    assign bus.memWrite  = w_mem_write;
    assign bus.memToReg  = w_mem_to_reg;
    assign bus.done      = w_done;
    assign bus.error     = w_error;
    assign bus.state     = r_state;
    assign bus.retired   = r_retired;

endmodule : multi_cycle_control
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_control
// Brief    : Self-checking bench: vector table with scoreboard plus corner cases.
// Revision : 1.0
// ============================================================================
module tb_multi_cycle_control;

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_fetch = 3'd1;
    localparam logic [2:0] c_s_halt  = 3'd6;
    localparam logic [2:0] c_s_error = 3'd7;

    typedef struct {
        logic [2:0] op;
        int         w;     // memReady-low cycles in MEM; -1 = never ready
        int         lat;
        int         rd;
        int         wr;
        int         imm;
        int         rw;
        int         m2r;
        logic [2:0] fin;
    } vec_t;

    typedef struct {
        int         lat;
        int         rd;
        int         wr;
        int         imm;
        int         imm_bad;
        int         rw;
        int         m2r;
        int         nxt;
        logic [2:0] alu;
        logic [2:0] fin;
    } obs_t;

    logic clock;
    logic reset;

    multi_cycle_control_if #(.OP_W(3), .CNT_W(16)) bus ();

    multi_cycle_control u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;
    vec_t vecs[10];
    vec_t sb[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, " state"},    int'(bus.state), int'(c_s_idle));
        check({tag, " outputs"},  int'({bus.nextIns, bus.immediate, bus.regWrite, bus.memRead,
                                        bus.memWrite, bus.memToReg, bus.done, bus.error}), 0);
        check({tag, " aluOp"},    int'(bus.aluOp), 0);
        check({tag, " retired"},  int'(bus.retired), 0);
    endtask

    // Entered at a falling edge with the DUT in FETCH; returns at the falling
    // edge where FETCH, HALT or ERROR is next observed.
    task automatic run_instr(input logic [2:0] op, input int w, output obs_t o);
        o = '{default: 0};
        o.lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (k > 0 && (bus.state == c_s_fetch || bus.state == c_s_halt ||
                          bus.state == c_s_error)) begin
                o.lat = k;
                o.fin = bus.state;
                return;
            end
            o.nxt += int'(bus.nextIns);
            o.rd  += int'(bus.memRead);
            o.wr  += int'(bus.memWrite);
            o.imm += int'(bus.immediate);
            o.rw  += int'(bus.regWrite);
            o.m2r += int'(bus.memToReg);
            if (bus.immediate && bus.state != 3'd3) o.imm_bad++;
            if (k == 2) o.alu = bus.aluOp;
            bus.opcode   = (k == 1) ? op : ~op;
            bus.memReady = (w < 0) ? (k < 3) : (k < 3 || k >= 3 + w);
            @(negedge clock);
        end
        o.fin = bus.state;
    endtask

    task automatic do_reset(input int cycles);
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
        exp_retired = 0;
    endtask

    task automatic kick_start;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    initial begin
        obs_t o;
        vec_t e;

        //           op    w   lat rd wr imm rw m2r fin
        vecs[0] = '{3'd0,  0,  4,  0, 0, 0,  1, 0,  c_s_fetch};
        vecs[1] = '{3'd1,  0,  4,  0, 0, 0,  1, 0,  c_s_fetch};
        vecs[2] = '{3'd4,  0,  4,  0, 0, 1,  1, 0,  c_s_fetch};
        vecs[3] = '{3'd5,  3,  8,  4, 0, 0,  1, 1,  c_s_fetch};
        vecs[4] = '{3'd6,  0,  5,  0, 1, 0,  0, 0,  c_s_fetch};
        vecs[5] = '{3'd2,  0,  4,  0, 0, 0,  1, 0,  c_s_fetch};
        vecs[6] = '{3'd3,  0,  4,  0, 0, 0,  1, 0,  c_s_fetch};
        vecs[7] = '{3'd5,  0,  5,  1, 0, 0,  1, 1,  c_s_fetch};
        vecs[8] = '{3'd6,  2,  7,  0, 3, 0,  0, 0,  c_s_fetch};
        vecs[9] = '{3'd5, 15, 20, 16, 0, 0,  1, 1,  c_s_fetch};

        bus.start    = 1'b0;
        bus.opcode   = '0;
        bus.memReady = 1'b0;
        reset        = 1'b1;
        @(negedge clock);

        // Reset with start low, then release and confirm IDLE holds.
        do_reset(5);
        check_idle_quiet("reset");
        @(negedge clock);
        check_idle_quiet("idle hold");
        kick_start();
        check("start->fetch", int'(bus.state), int'(c_s_fetch));
        check("fetch nextIns", int'(bus.nextIns), 1);

        // Table-driven instruction stream through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            sb.push_back(vecs[i]);
            run_instr(vecs[i].op, vecs[i].w, o);
            e = sb.pop_front();
            if (e.fin == c_s_fetch) exp_retired++;
            check($sformatf("v%0d latency", i),   o.lat,          e.lat);
            check($sformatf("v%0d memRead", i),   o.rd,           e.rd);
            check($sformatf("v%0d memWrite", i),  o.wr,           e.wr);
            check($sformatf("v%0d immediate", i), o.imm,          e.imm);
            check($sformatf("v%0d imm_state", i), o.imm_bad,      0);
            check($sformatf("v%0d regWrite", i),  o.rw,           e.rw);
            check($sformatf("v%0d memToReg", i),  o.m2r,          e.m2r);
            check($sformatf("v%0d nextIns", i),   o.nxt,          1);
            check($sformatf("v%0d aluOp", i),     int'(o.alu),    int'(e.op));
            check($sformatf("v%0d end", i),       int'(o.fin),    int'(e.fin));
            check($sformatf("v%0d retired", i),   int'(bus.retired), exp_retired);
        end

        // Load that never completes: 16 MEM cycles, then sticky ERROR.
        run_instr(3'd5, -1, o);
        check("timeout memRead", o.rd, 16);
        check("timeout latency", o.lat, 19);
        check("timeout end", int'(o.fin), int'(c_s_error));
        check("timeout error", int'(bus.error), 1);
        check("timeout retired", int'(bus.retired), exp_retired);
        for (int k = 0; k < 4; k++) begin
            bus.start    = k[0];
            bus.memReady = 1'b1;
            @(negedge clock);
        end
        check("error sticky", int'(bus.state), int'(c_s_error));
        check("error sticky flag", int'(bus.error), 1);
        do_reset(1);
        check_idle_quiet("error reset");

        // Three ADDs then HALT.
        kick_start();
        for (int i = 0; i < 3; i++) begin
            run_instr(3'd0, 0, o);
            check($sformatf("add%0d latency", i), o.lat, 4);
        end
        run_instr(3'd7, 0, o);
        check("halt latency", o.lat, 2);
        check("halt end", int'(o.fin), int'(c_s_halt));
        check("halt done", int'(bus.done), 1);
        check("halt retired", int'(bus.retired), 3);
        check("halt aluOp", int'(bus.aluOp), 7);
        for (int k = 0; k < 4; k++) begin
            bus.start = ~k[0];
            @(negedge clock);
        end
        check("halt sticky", int'(bus.state), int'(c_s_halt));
        check("halt sticky done", int'(bus.done), 1);

        // Reset asserted while a store waits in MEM.
        do_reset(1);
        check_idle_quiet("halt reset");
        kick_start();
        run_instr(3'd0, 0, o);
        check("pre-st retired", int'(bus.retired), 1);
        bus.memReady = 1'b0;
        @(negedge clock);
        bus.opcode = 3'd6;
        @(negedge clock);
        bus.opcode = 3'd0;
        @(negedge clock);
        check("st mem state", int'(bus.state), 4);
        check("st memWrite", int'(bus.memWrite), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid-reset state", int'(bus.state), int'(c_s_idle));
        check("mid-reset memWrite", int'(bus.memWrite), 0);
        check("mid-reset retired", int'(bus.retired), 0);
        check("mid-reset regWrite", int'(bus.regWrite), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multi_cycle_control
`default_nettype wire

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Parametrised multi-cycle control FSM, successor to the 4-state processor controller.
- Sits between instruction fetch/decode and the datapath. Sequences each instruction through FETCH/DECODE/EXECUTE/(MEM)/WRITEBACK.
- Adds to the previous controller:
  - generalised opcode width;
  - mask-driven immediate and writeback selection;
  - memory ready handshake with timeout;
  - start/halt/error states;
  - retired-instruction counter.

Parameters:
- OP_W, 3, opcode width in bits.
- IMM_MASK, 8'b0001_0000, bit k set means opcode k uses the immediate path (width 2**OP_W).
- WB_MASK, 8'b0011_1111, bit k set means opcode k writes the register file (width 2**OP_W).
- LD_OP, 5, load opcode.
- ST_OP, 6, store opcode.
- HALT_OP, 7, halt opcode.
- MEM_TIMEOUT, 15, maximum wait cycles for memReady before the ERROR state.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching.
- opcode  in  OP_W  opcode of the current instruction; valid in DECODE.
- memReady  in  1  data memory has completed the requested access.
- aluOp  out  OP_W  latched opcode, driven to the ALU.
- nextIns  out  1  advance the PC; one cycle, in FETCH.
- immediate  out  1  select the immediate operand.
- regWrite  out  1  register-file write enable.
- memRead  out  1  data-memory read request.
- memWrite  out  1  data-memory write request.
- memToReg  out  1  select memory data for the writeback value.
- done  out  1  high while in HALT.
- error  out  1  high while in ERROR.
- state  out  3  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (synchronous, active-high):
  - state forced to IDLE; opReg, waitCnt and retired cleared to 0.
  - All outputs 0.
  - Reset asserted mid-instruction abandons it; nothing is written that cycle.
- Outputs are Moore: decoded from the registered state and opReg only, with no combinational path from inputs.
- aluOp equals opReg at all times.
- States and transitions:
  - IDLE: all outputs 0; go to FETCH when start=1, else stay.
  - FETCH: nextIns=1; go to DECODE.
  - DECODE: opReg <= opcode. If opcode==HALT_OP, go to HALT. Otherwise go to EXECUTE.
  - EXECUTE: immediate = IMM_MASK[opReg]. If opReg is LD_OP or ST_OP, go to MEM and clear waitCnt. Otherwise go to WRITEBACK.
  - MEM:
    - memRead = (opReg==LD_OP); memWrite = (opReg==ST_OP); both held until handshake.
    - memReady=1 in the same cycle: go to WRITEBACK.
    - Else if waitCnt==MEM_TIMEOUT: go to ERROR.
    - Else waitCnt++.
  - WRITEBACK:
    - regWrite = WB_MASK[opReg] && opReg!=ST_OP.
    - memToReg = (opReg==LD_OP).
    - retired++ (wraps modulo 2**CNT_W); go to FETCH.
  - HALT: done=1; sticky until reset; start is ignored.
  - ERROR: error=1; sticky until reset.
- Latency (FETCH to the next FETCH):
  - non-memory op: 4 cycles;
  - LD/ST: 5+w cycles, where w = cycles memReady is low in MEM, with w ≤ MEM_TIMEOUT.
  - Timeout is entered after MEM_TIMEOUT+1 MEM cycles with memReady low.
- memReady outside MEM is ignored.
- opcode outside DECODE is ignored.
- ST_OP is never written back even if its WB_MASK bit is set.
- HALT_OP takes priority over mask bits.

Decomposition:
- Shared definitions package additions:
  - state typedef (enum, 3 bits): IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6, ERROR=7;
  - default opcode constants and default mask constants.
- One natural sub-module: mem_wait_timer. It holds the waitCnt counter, with inputs clear and enable and output expired.

Test Plan:
- Reset with start=0 for 5 cycles → state=IDLE, all outputs 0, retired=0. Then start=1 with opcode=0 (ADD) → nextIns high in cycle 1, regWrite high in cycle 4, retired=1, FETCH again in cycle 5.
- opcode=4 (MOV) → immediate=1 only in EXECUTE, regWrite=1 in WRITEBACK, memToReg=0.
- opcode=5 (LD) with memReady held low 3 cycles then high → memRead high for 4 MEM cycles, then regWrite=1 and memToReg=1. FETCH-to-FETCH = 8 cycles.
- opcode=6 (ST) with memReady=1 immediately → memWrite high for exactly 1 cycle, regWrite stays 0, retired increments.
- LD with memReady never asserted → memRead high for 16 cycles, then error=1 and sticky. Reset → IDLE, error=0.
- opcode=7 (HALT) after 3 ADDs → done=1, retired=3, and start toggling has no effect.
- Reset asserted during MEM of an ST → next cycle state=IDLE, memWrite=0, retired cleared.
